// File: rtl/uart_word_rx_if.sv
// Word handoff between the UART receiver and its downstream consumer.
// The receiver is the master: it presents word_data/word_valid and the
// consumer answers with word_ready.
interface uart_word_rx_if;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs four LSB-first bytes, little-endian, into a
// 32-bit word and hands it downstream over a valid/ready interface.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge (start bit)
// S_START | waiting to mid-bit of the start bit to confirm it
// S_DATA  | sampling the eight data bits at mid-bit
// S_STOP  | sampling the stop bit; high delivers the byte
// S_BREAK | stop bit was low; wait for the line to return high
module uart_word_rx #(
    parameter int SERIAL_WCNT = 50,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           rxd,
    uart_word_rx_if.master bus,
    output logic           err_frame,
    output logic           err_overrun,
    output logic           err_timeout,
    output logic [31:0]    word_count
);
    localparam int TW = $clog2(SERIAL_WCNT);
    localparam int IW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] HALF_LOAD = TW'(SERIAL_WCNT / 2 - 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(SERIAL_WCNT - 1);
    localparam logic [IW-1:0] IDLE_LOAD = IW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        state, state_next;
    logic          rxd_m, rxd_s;
    logic [TW-1:0] timer, timer_val;
    logic          timer_load;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          sample_data, byte_stb, frame_err;
    logic [1:0]    byte_idx;
    logic [23:0]   lanes;
    logic [IW-1:0] idle_timer;
    logic          timeout_hit, complete, accept;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Bit FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    // Bit FSM next state and per-cycle strobes.
    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_val   = BIT_LOAD;
        sample_data = 1'b0;
        byte_stb    = 1'b0;
        frame_err   = 1'b0;
        case (state)
            S_IDLE: if (!rxd_s) begin
                state_next = S_START;
                timer_load = 1'b1;
                timer_val  = HALF_LOAD;
            end
            S_START: if (timer == '0) begin
                if (rxd_s) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_DATA;
                    timer_load = 1'b1;
                end
            end
            S_DATA: if (timer == '0) begin
                sample_data = 1'b1;
                timer_load  = 1'b1;
                if (bit_idx == 3'd7) state_next = S_STOP;
            end
            S_STOP: if (timer == '0) begin
                if (rxd_s) begin
                    byte_stb   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    frame_err  = 1'b1;
                    state_next = S_BREAK;
                end
            end
            S_BREAK: if (rxd_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bit timer, bit index and data shift register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer   <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (timer_load)        timer <= timer_val;
            else if (timer != '0)  timer <= timer - TW'(1);
            if (state == S_START)  bit_idx <= 3'd0;
            else if (sample_data)  bit_idx <= bit_idx + 3'd1;
            if (sample_data)       shreg[bit_idx] <= rxd_s;
        end
    end

    // Byte strobe takes priority over the timeout, so a fresh byte is never lost.
    assign timeout_hit = !byte_stb && (byte_idx != 2'd0) && (state == S_IDLE) && (idle_timer == '0);
    assign complete    = byte_stb && (byte_idx == 2'd3);
    assign accept      = bus.word_valid && bus.word_ready;

    // Byte lanes, byte index and idle timeout down-counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lanes       <= '0;
            byte_idx    <= 2'd0;
            idle_timer  <= IDLE_LOAD;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (byte_stb) begin
                case (byte_idx)
                    2'd0:    lanes[7:0]   <= shreg;
                    2'd1:    lanes[15:8]  <= shreg;
                    2'd2:    lanes[23:16] <= shreg;
                    default: ;
                endcase
                byte_idx <= byte_idx + 2'd1;
            end else if (timeout_hit) begin
                byte_idx <= 2'd0;
            end
            if (byte_stb || byte_idx == 2'd0 || timeout_hit) idle_timer <= IDLE_LOAD;
            else if (state == S_IDLE)                        idle_timer <= idle_timer - IW'(1);
        end
    end

    // Holding register, handshake, accepted-word counter and error pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.word_data  <= '0;
            bus.word_valid <= 1'b0;
            word_count     <= '0;
            err_overrun    <= 1'b0;
            err_frame      <= 1'b0;
        end else begin
            err_frame   <= frame_err;
            err_overrun <= complete && bus.word_valid && !bus.word_ready;
            if (complete && (!bus.word_valid || accept)) begin
                bus.word_data  <= {shreg, lanes};
                bus.word_valid <= 1'b1;
            end else if (accept) begin
                bus.word_valid <= 1'b0;
            end
            if (accept) word_count <= word_count + 32'd1;
        end
    end
endmodule
